// File: rtl/hdc_mon_pkg.sv
// Shared constants and tag layout for the HDC latency monitor.
package hdc_mon_pkg;

  localparam int DEF_NUM_LABELS = 2;
  localparam int DEF_TAG_DEPTH  = 16;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_SKIP_FIRST = 2;

  // In-flight tag at default widths: issue timestamp plus expected labels.
  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0]  start;
    logic [DEF_NUM_LABELS-1:0] labels;
  } hdc_tag_t;

endpackage

// File: rtl/hdc_latency_monitor_if.sv
// Observed upstream/downstream handshake of the classifier under monitoring.
interface hdc_latency_monitor_if #(
  parameter int NUM_LABELS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_LABELS-1:0] in_exp_labels;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_LABELS-1:0] out_labels;

  modport master (
    output in_valid, in_ready, in_exp_labels,
    output out_valid, out_ready, out_labels
  );

  modport slave (
    input in_valid, in_ready, in_exp_labels,
    input out_valid, out_ready, out_labels
  );
endinterface

// File: rtl/hdc_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered pointers, head visible combinationally.
module hdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;

  // Extra pointer MSB separates full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/hdc_latency_monitor.sv
// Passive latency/label monitor: tags each input fire, retires on output fire, keeps stats.
module hdc_latency_monitor
  import hdc_mon_pkg::*;
#(
  parameter int NUM_LABELS = DEF_NUM_LABELS,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int SKIP_FIRST = DEF_SKIP_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  hdc_latency_monitor_if.slave  hs,
  output logic [CNT_WIDTH-1:0]  in_stall_cnt,
  output logic [CNT_WIDTH-1:0]  in_idle_cnt,
  output logic [CNT_WIDTH-1:0]  out_stall_cnt,
  output logic [CNT_WIDTH-1:0]  out_idle_cnt,
  output logic [CNT_WIDTH-1:0]  entry_cnt,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic [CNT_WIDTH-1:0]  lat_sum,
  output logic [CNT_WIDTH-1:0]  lat_max,
  output logic [CNT_WIDTH-1:0]  lat_min,
  output logic [CNT_WIDTH-1:0]  lat_last,
  output logic                  overflow,
  output logic                  underflow,
  output logic [NUM_LABELS-1:0] last_mismatch
);
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  // Same layout as hdc_tag_t, sized by this instance's parameters.
  typedef struct packed {
    cnt_t                  start;
    logic [NUM_LABELS-1:0] labels;
  } entry_t;

  function automatic cnt_t sat_add(cnt_t a, cnt_t b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic   flush, in_fire, out_fire, push, pop, full, empty;
  entry_t head, tail;
  cnt_t   lat, pc;
  logic [NUM_LABELS-1:0] mm;

  cnt_t cycle_q, cycle_d, in_stall_q, in_stall_d, in_idle_q, in_idle_d;
  cnt_t out_stall_q, out_stall_d, out_idle_q, out_idle_d, entry_q, entry_d;
  cnt_t mis_q, mis_d, sum_q, sum_d, max_q, max_d, min_q, min_d, last_q, last_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic [NUM_LABELS-1:0] lmm_q, lmm_d;

  assign flush    = rst | clear;
  assign in_fire  = ~flush & hs.in_valid & hs.in_ready;
  assign out_fire = ~flush & hs.out_valid & hs.out_ready;
  // Pop sees only registered occupancy, so a push into an empty FIFO cannot be bypassed.
  assign pop      = out_fire & ~empty;
  assign push     = in_fire & (~full | pop);
  assign tail     = '{start: cycle_q, labels: hs.in_exp_labels};

  hdc_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (TAG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (tail),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign lat = cycle_q - head.start;
  assign mm  = hs.out_labels ^ head.labels;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_LABELS; i++) pc = pc + cnt_t'(mm[i]);
  end

  always_comb begin
    cycle_d     = cycle_q + 1'b1;
    in_stall_d  = in_stall_q;
    in_idle_d   = in_idle_q;
    out_stall_d = out_stall_q;
    out_idle_d  = out_idle_q;
    entry_d     = entry_q;
    mis_d       = mis_q;
    sum_d       = sum_q;
    max_d       = max_q;
    min_d       = min_q;
    last_d      = last_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    lmm_d       = lmm_q;
    if (hs.in_valid & ~hs.in_ready)   in_stall_d  = sat_add(in_stall_q, cnt_t'(1));
    if (~hs.in_valid & hs.in_ready)   in_idle_d   = sat_add(in_idle_q, cnt_t'(1));
    if (hs.out_valid & ~hs.out_ready) out_stall_d = sat_add(out_stall_q, cnt_t'(1));
    if (~hs.out_valid & hs.out_ready) out_idle_d  = sat_add(out_idle_q, cnt_t'(1));
    if (in_fire & ~push) ovf_d = 1'b1;
    if (out_fire & empty) udf_d = 1'b1;
    if (pop) begin
      entry_d = sat_add(entry_q, cnt_t'(1));
      last_d  = lat;
      sum_d   = sat_add(sum_q, lat);
      if (lat > max_q) max_d = lat;
      if (lat < min_q) min_d = lat;
      // Warm-up entries are timed but not scored.
      if (entry_q >= cnt_t'(SKIP_FIRST)) begin
        lmm_d = mm;
        mis_d = sat_add(mis_q, pc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      cycle_q     <= '0;
      in_stall_q  <= '0;
      in_idle_q   <= '0;
      out_stall_q <= '0;
      out_idle_q  <= '0;
      entry_q     <= '0;
      mis_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      min_q       <= '1;
      last_q      <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      lmm_q       <= '0;
    end else begin
      cycle_q     <= cycle_d;
      in_stall_q  <= in_stall_d;
      in_idle_q   <= in_idle_d;
      out_stall_q <= out_stall_d;
      out_idle_q  <= out_idle_d;
      entry_q     <= entry_d;
      mis_q       <= mis_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      min_q       <= min_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      lmm_q       <= lmm_d;
    end
  end

  assign in_stall_cnt  = in_stall_q;
  assign in_idle_cnt   = in_idle_q;
  assign out_stall_cnt = out_stall_q;
  assign out_idle_cnt  = out_idle_q;
  assign entry_cnt     = entry_q;
  assign mismatch_cnt  = mis_q;
  assign lat_sum       = sum_q;
  assign lat_max       = max_q;
  assign lat_min       = min_q;
  assign lat_last      = last_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign last_mismatch = lmm_q;
endmodule

// File: doc/hdc_latency_monitor.md
HDC_LATENCY_MONITOR -- requirements
Module: hdc_latency_monitor

Interface
REQ-001 SHALL have parameter NUM_LABELS, default 2, number of 1-bit classifier labels per entry (valence, arousal).
REQ-002 SHALL have parameter TAG_DEPTH, default 16, in-flight entry capacity, power of 2, >=2.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of all counters and timestamps.
REQ-004 SHALL have parameter SKIP_FIRST, default 2, number of initial retired entries excluded from label comparison.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port clear  input  1  synchronous statistics/FIFO clear, same effect as rst.
REQ-008 SHALL have ports in_valid, in_ready  input  1 each  observed upstream handshake (monitor never drives it).
REQ-009 SHALL have port in_exp_labels  input  NUM_LABELS  expected labels, sampled on input fire.
REQ-010 SHALL have ports out_valid, out_ready  input  1 each  observed downstream handshake.
REQ-011 SHALL have port out_labels  input  NUM_LABELS  DUT labels, sampled on output fire.
REQ-012 SHALL have outputs in_stall_cnt, in_idle_cnt, out_stall_cnt, out_idle_cnt  CNT_WIDTH each  handshake statistics.
REQ-013 SHALL have outputs entry_cnt, mismatch_cnt, lat_sum, lat_max, lat_min, lat_last  CNT_WIDTH each.
REQ-014 SHALL have outputs overflow, underflow  1 each  sticky error flags; last_mismatch  NUM_LABELS  per-label result of last compared entry.

Function
REQ-015 in fire = in_valid&in_ready; out fire = out_valid&out_ready; evaluated each rising edge.
REQ-016 in_stall_cnt +1 when in_valid&~in_ready; in_idle_cnt +1 when ~in_valid&in_ready; out_* likewise.
REQ-017 Free-running cycle counter, CNT_WIDTH, +1 per cycle, wraps modulo 2^CNT_WIDTH.
REQ-018 On in fire with FIFO not full: push {cycle, in_exp_labels}; visible to pop from next cycle (no bypass).
REQ-019 On in fire with FIFO full and no same-cycle pop: entry dropped, overflow set; with same-cycle pop: push accepted.
REQ-020 On out fire with FIFO non-empty: pop; latency = (cycle - start) mod 2^CNT_WIDTH; entry_cnt +1; lat_last = latency; lat_sum += latency; lat_max/lat_min updated.
REQ-021 On out fire with FIFO empty (including same-cycle push into empty): underflow set, no pop, no statistic other than out handshake counters changes.
REQ-022 Label compare only when entry_cnt (pre-increment) >= SKIP_FIRST: last_mismatch = out_labels ^ stored labels; mismatch_cnt += popcount(last_mismatch).
REQ-023 All counters saturate at 2^CNT_WIDTH-1 (cycle counter excepted); lat_sum saturates independently.
REQ-024 Results registered: statistics reflect a fire one cycle after the fire edge.
REQ-025 Simultaneous push and pop SHALL both complete; occupancy unchanged.

Reset
REQ-026 On rst or clear: all counters 0, lat_min all-ones, lat_max 0, last_mismatch 0, overflow/underflow 0, FIFO empty, cycle counter 0.
REQ-027 Fires on a cycle with rst or clear asserted SHALL be ignored; in-flight entries discarded.

Structure
REQ-028 Package hdc_mon_pkg SHALL hold default parameter constants and the FIFO entry struct {start timestamp, labels}.
REQ-029 One sub-module hdc_sync_fifo (parametrised width/depth, push/pop/full/empty, synchronous reset) SHALL hold tags.
REQ-030 Monitor SHALL be synthesisable and drive no handshake signal of the observed DUT.

Verification
REQ-031 5 entries, each in fire at cycle t, out fire at t+10, labels equal -> entry_cnt=5, lat_min=lat_max=10, lat_sum=50, mismatch_cnt=0.
REQ-032 Entries 0,1 with wrong labels, entry 2 with both labels wrong, SKIP_FIRST=2 -> mismatch_cnt=2, last_mismatch=2'b11.
REQ-033 17 in fires with no out fire, TAG_DEPTH=16 -> overflow=1 after 17th; then 16 out fires -> entry_cnt=16, underflow=0.
REQ-034 out fire with empty FIFO -> underflow=1, entry_cnt unchanged; simultaneous push+pop at full -> occupancy stays 16, overflow stays 0.
REQ-035 in_valid high, in_ready low 7 cycles; out_ready high, out_valid low 3 cycles -> in_stall_cnt=7, out_idle_cnt=3.
REQ-036 clear pulsed with 4 entries in flight -> all outputs at reset values next cycle; subsequent out fire -> underflow=1.
